// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and types for the write-back stage
package cpu_pkg;

   localparam int DATA_W    = 64;
   localparam int REG_IDX_W = 5;

   typedef logic [DATA_W-1:0]    word_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // Index of the hardwired zero register (XZR).
   localparam reg_idx_t REG_ZR = 5'd31;

endpackage

// File: rtl/regfile_decoder.sv
// rtl/regfile_decoder.sv - one-hot GPR write-enable decoder gated by the effective write
module regfile_decoder
   import cpu_pkg::*;
#(
   parameter int NREGS = 32
) (
   input  logic             we,
   input  reg_idx_t         idx,
   output logic [NREGS-2:0] wr_en
);

   // Only slots with storage get an enable; the zero register has none.
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < NREGS - 1; i++) begin
         wr_en[i] = we && (idx == reg_idx_t'(i));
      end
   end

endmodule

// File: rtl/register.sv
// rtl/register.sv - enabled storage word with synchronous active-high clear
module register #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Clear on reset, otherwise load d when enabled.
   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - WB result select, 32x64 GPR file with XZR, commit counter; option WB_BYPASS_EN
module wb_regfile
   import cpu_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int NREGS  = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              regWrite_E_WB,
   input  reg_idx_t          regWrite_WB,
   input  logic              shiftsel_WB,
   input  logic [DATA_W-1:0] WriteData_WB,
   input  logic [DATA_W-1:0] shift_output_WB,
   input  reg_idx_t          ReadReg1,
   input  reg_idx_t          ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   output logic [DATA_W-1:0] wb_result,
   output logic [CNT_W-1:0]  commit_count
);

   logic              we_eff;
   logic [NREGS-2:0]  wr_en;
   logic [DATA_W-1:0] gpr [NREGS];

   assign wb_result = shiftsel_WB ? shift_output_WB : WriteData_WB;

   // Writes to XZR and writes in a reset cycle never take effect.
   assign we_eff = regWrite_E_WB && (regWrite_WB != REG_ZR) && !reset;

   regfile_decoder #(.NREGS(NREGS)) u_dec (
      .we    (we_eff),
      .idx   (regWrite_WB),
      .wr_en (wr_en)
   );

   for (genvar g = 0; g < NREGS - 1; g++) begin : g_gpr
      register #(DATA_W) u_reg (
         .clk   (clk),
         .reset (reset),
         .en    (wr_en[g]),
         .d     (wb_result),
         .q     (gpr[g])
      );
   end

   assign gpr[NREGS-1] = '0;

`ifdef WB_BYPASS_EN
   // we_eff is never true for XZR, so the zero register stays zero under bypass.
   assign ReadData1 = (we_eff && (ReadReg1 == regWrite_WB)) ? wb_result : gpr[ReadReg1];
   assign ReadData2 = (we_eff && (ReadReg2 == regWrite_WB)) ? wb_result : gpr[ReadReg2];
`else
   assign ReadData1 = gpr[ReadReg1];
   assign ReadData2 = gpr[ReadReg2];
`endif

   // Count effective commits; wraps silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         commit_count <= '0;
      end else if (we_eff) begin
         commit_count <= commit_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - randomized model-checked bench for wb_regfile (CNT_W=4)
module tb_wb_regfile;

   logic        clk;
   logic        reset;
   logic        regWrite_E_WB;
   logic [4:0]  regWrite_WB;
   logic        shiftsel_WB;
   logic [63:0] WriteData_WB;
   logic [63:0] shift_output_WB;
   logic [4:0]  ReadReg1;
   logic [4:0]  ReadReg2;
   logic [63:0] ReadData1;
   logic [63:0] ReadData2;
   logic [63:0] wb_result;
   logic [3:0]  commit_count;

   int checks = 0;
   int errors = 0;

   logic [63:0] model_gpr [32];
   int          model_cnt;
   bit          chk_en = 0;

   wb_regfile #(.DATA_W(64), .NREGS(32), .CNT_W(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .regWrite_E_WB   (regWrite_E_WB),
      .regWrite_WB     (regWrite_WB),
      .shiftsel_WB     (shiftsel_WB),
      .WriteData_WB    (WriteData_WB),
      .shift_output_WB (shift_output_WB),
      .ReadReg1        (ReadReg1),
      .ReadReg2        (ReadReg2),
      .ReadData1       (ReadData1),
      .ReadData2       (ReadData2),
      .wb_result       (wb_result),
      .commit_count    (commit_count)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] exp_read(input logic [4:0] rr, input bit we,
                                            input logic [4:0] wi, input logic [63:0] wv);
      if (rr == 5'd31) return 64'd0;
`ifdef WB_BYPASS_EN
      if (we && rr == wi) return wv;
`endif
      return model_gpr[rr];
   endfunction

   // Architectural model: what each clock edge must do to the register state.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) model_gpr[i] <= 64'd0;
         model_cnt <= 0;
         chk_en    <= 1;
      end else if (regWrite_E_WB && regWrite_WB != 5'd31) begin
         model_gpr[regWrite_WB] <= shiftsel_WB ? shift_output_WB : WriteData_WB;
         model_cnt <= (model_cnt + 1) % 16;
      end
   end

   // Compare every output against the model mid-cycle.
   always @(negedge clk) begin
      logic [63:0] wv;
      bit          we;
      if (chk_en) begin
         wv = shiftsel_WB ? shift_output_WB : WriteData_WB;
         we = regWrite_E_WB && regWrite_WB != 5'd31 && !reset;
         check("wb_result", wb_result, wv);
         check("ReadData1", ReadData1, exp_read(ReadReg1, we, regWrite_WB, wv));
         check("ReadData2", ReadData2, exp_read(ReadReg2, we, regWrite_WB, wv));
         check("commit_count", 64'(commit_count), 64'(model_cnt));
      end
   end

   task automatic drive(input bit rst, input bit en, input logic [4:0] idx, input bit ss,
                        input logic [63:0] wd, input logic [63:0] sh,
                        input logic [4:0] r1, input logic [4:0] r2);
      reset = rst; regWrite_E_WB = en; regWrite_WB = idx; shiftsel_WB = ss;
      WriteData_WB = wd; shift_output_WB = sh; ReadReg1 = r1; ReadReg2 = r2;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] idx, input logic [63:0] v);
      drive(0, 1, idx, 0, v, 64'd0, 5'd0, 5'd0);
      next_cycle();
   endtask

   initial begin
      drive(1, 1, 5'd3, 0, 64'hDEAD, 64'd0, 5'd3, 5'd3);
      next_cycle();
      next_cycle();

      // Reset discards the write held during it.
      drive(0, 0, 5'd3, 0, 64'hDEAD, 64'd0, 5'd3, 5'd3);
      @(negedge clk);
      check("reset_x3", ReadData1, 64'd0);
      check("reset_cnt", 64'(commit_count), 64'd0);
      next_cycle();

      // Write through both WB sources.
      drive(0, 1, 5'd5, 0, 64'h0123_4567_89AB_CDEF, 64'd0, 5'd0, 5'd0);
      next_cycle();
      drive(0, 1, 5'd6, 1, 64'hBAD, 64'h10, 5'd0, 5'd0);
      next_cycle();
      drive(0, 0, 5'd0, 0, 64'd0, 64'd0, 5'd5, 5'd6);
      @(negedge clk);
      check("read_x5", ReadData1, 64'h0123_4567_89AB_CDEF);
      check("read_x6", ReadData2, 64'h10);
      check("cnt_two", 64'(commit_count), 64'd2);
      next_cycle();

      // XZR writes are dropped.
      drive(0, 1, 5'd31, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd31, 5'd31);
      @(negedge clk);
      check("xzr_same", ReadData1, 64'd0);
      next_cycle();
      drive(0, 0, 5'd0, 0, 64'd0, 64'd0, 5'd31, 5'd31);
      @(negedge clk);
      check("xzr_after", ReadData1, 64'd0);
      check("xzr_cnt", 64'(commit_count), 64'd2);
      next_cycle();

      // Same-cycle write/read hazard on X7.
      write_reg(5'd7, 64'd1);
      drive(0, 1, 5'd7, 0, 64'h42, 64'd0, 5'd7, 5'd7);
      @(negedge clk);
`ifdef WB_BYPASS_EN
      check("hazard_rd1", ReadData1, 64'h42);
      check("hazard_rd2", ReadData2, 64'h42);
`else
      check("hazard_rd1", ReadData1, 64'd1);
      check("hazard_rd2", ReadData2, 64'd1);
`endif
      next_cycle();
      drive(0, 0, 5'd0, 0, 64'd0, 64'd0, 5'd7, 5'd7);
      @(negedge clk);
      check("hazard_next1", ReadData1, 64'h42);
      check("hazard_next2", ReadData2, 64'h42);
      next_cycle();

      // Disabled write leaves X9 and the counter alone.
      write_reg(5'd9, 64'h55);
      drive(0, 0, 5'd9, 0, 64'hAA, 64'd0, 5'd9, 5'd9);
      next_cycle();
      drive(0, 0, 5'd0, 0, 64'd0, 64'd0, 5'd9, 5'd9);
      @(negedge clk);
      check("disabled_x9", ReadData1, 64'h55);
      check("disabled_cnt", 64'(commit_count), 64'd5);
      next_cycle();

      // Counter wrap over 17 effective writes from reset.
      drive(1, 0, 5'd0, 0, 64'd0, 64'd0, 5'd0, 5'd0);
      next_cycle();
      for (int i = 1; i <= 17; i++) begin
         write_reg(5'(i % 31), 64'(i));
         drive(0, 0, 5'd0, 0, 64'd0, 64'd0, 5'd1, 5'd2);
         @(negedge clk);
         if (i == 15) check("wrap_15", 64'(commit_count), 64'd15);
         if (i == 16) check("wrap_0", 64'(commit_count), 64'd0);
         if (i == 17) check("wrap_1", 64'(commit_count), 64'd1);
         @(posedge clk);
         #1;
      end

      // Reset mid-stream wins over a pending write.
      write_reg(5'd4, 64'h77);
      drive(1, 1, 5'd4, 0, 64'h99, 64'd0, 5'd4, 5'd4);
      next_cycle();
      drive(0, 0, 5'd4, 0, 64'd0, 64'd0, 5'd4, 5'd4);
      @(negedge clk);
      check("midreset_cnt", 64'(commit_count), 64'd0);
      check("midreset_x4", ReadData1, 64'd0);
      next_cycle();

      // Randomized traffic; reads aimed at the write target a quarter of the time.
      for (int i = 0; i < 400; i++) begin
         logic [4:0] idx;
         idx = 5'($urandom_range(0, 31));
         drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), idx,
               1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? idx : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 3) == 0) ? idx : 5'($urandom_range(0, 31)));
         next_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
